// File: rtl/tqvp_vga_copper.sv
// rtl/tqvp_vga_copper.sv - display-list sequencer replaying timed VGA register writes each frame
module tqvp_vga_copper #(
  parameter int LIST_DEPTH = 16,
  parameter int PC_W       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            frame_start,
  input  logic [9:0]      vga_y,
  input  logic            vga_blank,
  input  logic            list_we,
  input  logic [PC_W-1:0] list_addr,
  input  logic [31:0]     list_wdata,
  input  logic [5:0]      cpu_address,
  input  logic [31:0]     cpu_data_in,
  input  logic [1:0]      cpu_data_write_n,
  output logic            cpu_write_ready,
  output logic [5:0]      vga_address,
  output logic [31:0]     vga_data_in,
  output logic [1:0]      vga_data_write_n,
  output logic            busy,
  output logic [PC_W-1:0] pc,
  output logic            done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(LIST_DEPTH - 1);

  // Only the meaningful fields of an entry are stored: {data, addr, end, y}.
  logic [24:0] list_mem [LIST_DEPTH];

  state_t      state;
  logic [9:0]  cur_y;
  logic        cur_end;
  logic [5:0]  cur_addr;
  logic [7:0]  cur_data;

  logic        cur_last;
  logic        unused_bits;

  assign cur_last    = cur_end || (pc == LAST_PC);
  assign unused_bits = ^{list_wdata[23:22], list_wdata[14:10]};

  // List storage: CPU-side writes land at any time, contents need no reset.
  always_ff @(posedge clk) begin
    if (list_we) begin
      list_mem[list_addr] <= {list_wdata[31:24], list_wdata[21:16], list_wdata[15], list_wdata[9:0]};
    end
  end

  // Sequencer FSM: enable low dominates, then frame restart, then normal list walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= '0;
      cur_y    <= '0;
      cur_end  <= 1'b0;
      cur_addr <= '0;
      cur_data <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!enable) begin
        state <= S_IDLE;
        pc    <= '0;
        busy  <= 1'b0;
      end else if (frame_start) begin
        state <= S_FETCH;
        pc    <= '0;
        busy  <= 1'b1;
      end else begin
        case (state)
          S_FETCH: begin
            {cur_data, cur_addr, cur_end, cur_y} <= list_mem[pc];
            state <= S_WAIT;
          end
          S_WAIT: begin
            if (vga_blank && (vga_y >= cur_y)) begin
              state <= S_WRITE;
              done  <= cur_last;
            end
          end
          S_WRITE: begin
            if (cur_last) begin
              state <= S_DONE;
              busy  <= 1'b0;
            end else begin
              pc    <= pc + 1'b1;
              state <= S_FETCH;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Bus arbitration: the copper owns the peripheral port for its single WRITE cycle.
  always_comb begin
    vga_address      = cpu_address;
    vga_data_in      = cpu_data_in;
    vga_data_write_n = cpu_data_write_n;
    cpu_write_ready  = 1'b1;
    if (state == S_WRITE) begin
      vga_address      = cur_addr;
      vga_data_in      = {24'b0, cur_data};
      vga_data_write_n = 2'b00;
      cpu_write_ready  = 1'b0;
    end
  end

endmodule

// File: tb/tb_tqvp_vga_copper.sv
// tb/tb_tqvp_vga_copper.sv - scoreboard bench for the copper with a timestamp-based reference model
module tb_tqvp_vga_copper;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        frame_start;
  logic [9:0]  vga_y;
  logic        vga_blank;
  logic        list_we;
  logic [3:0]  list_addr;
  logic [31:0] list_wdata;
  logic [5:0]  cpu_address;
  logic [31:0] cpu_data_in;
  logic [1:0]  cpu_data_write_n;
  logic        cpu_write_ready;
  logic [5:0]  vga_address;
  logic [31:0] vga_data_in;
  logic [1:0]  vga_data_write_n;
  logic        busy;
  logic [3:0]  pc;
  logic        done;

  tqvp_vga_copper #(.LIST_DEPTH(DEPTH), .PC_W(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start),
    .vga_y(vga_y), .vga_blank(vga_blank), .list_we(list_we),
    .list_addr(list_addr), .list_wdata(list_wdata),
    .cpu_address(cpu_address), .cpu_data_in(cpu_data_in),
    .cpu_data_write_n(cpu_data_write_n), .cpu_write_ready(cpu_write_ready),
    .vga_address(vga_address), .vga_data_in(vga_data_in),
    .vga_data_write_n(vga_data_write_n), .busy(busy), .pc(pc), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit mon_on = 0;
  bit rnd_on = 0;
  bit cpu_hold = 0;

  typedef struct {
    longint     c;
    logic [5:0] a;
    logic [7:0] d;
    bit         l;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: list image, entry index, cycle from which the next entry may fire.
  logic [31:0] m_list [DEPTH];
  logic [31:0] m_cur;
  bit          m_run = 0;
  int          m_idx = 0;
  longint      m_ready = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] entry(input int y, input bit e, input int a, input int d);
    logic [31:0] w;
    w = '0;
    w[9:0] = 10'(y);
    w[15] = e;
    w[21:16] = 6'(a);
    w[31:24] = 8'(d);
    return w;
  endfunction

  function automatic logic [31:0] rand_entry();
    logic [31:0] w;
    w = $urandom;
    w[9:0] = ($urandom_range(0, 19) == 0) ? 10'd900 : 10'($urandom_range(0, 15));
    w[15] = ($urandom_range(0, 7) == 0);
    return w;
  endfunction

  // Model step for the inputs held during the current cycle.
  task automatic model_eval();
    bit last;
    if (m_run && cyc == m_ready - 1) m_cur = m_list[m_idx];
    if (list_we) m_list[list_addr] = list_wdata;
    if (!enable) begin
      m_run = 0;
    end else if (frame_start) begin
      m_run = 1;
      m_idx = 0;
      m_ready = cyc + 2;
    end else if (m_run && cyc >= m_ready && vga_blank && vga_y >= m_cur[9:0]) begin
      last = m_cur[15] || (m_idx == DEPTH - 1);
      exp_q.push_back('{c: cyc + 1, a: m_cur[21:16], d: m_cur[31:24], l: last});
      if (last) m_run = 0;
      else begin
        m_idx++;
        m_ready = cyc + 3;
      end
    end
  endtask

  task automatic cyc_step();
    if (rnd_on) begin
      if ($urandom_range(0, 299) == 0) frame_start = 1'b1;
      if ($urandom_range(0, 399) == 0) enable = ~enable;
      if ($urandom_range(0, 19) == 0) begin
        list_we = 1'b1;
        list_addr = 4'($urandom_range(0, 15));
        list_wdata = rand_entry();
      end
      if (!cpu_hold) begin
        cpu_address = 6'($urandom);
        cpu_data_in = $urandom;
        cpu_data_write_n = 2'($urandom);
      end
    end
    model_eval();
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    list_we = 1'b0;
  endtask

  task automatic line(input int y, input int act, input int blk);
    vga_y = 10'(y);
    vga_blank = 1'b0;
    repeat (act) cyc_step();
    vga_blank = 1'b1;
    repeat (blk) cyc_step();
  endtask

  task automatic wr_entry(input int idx, input logic [31:0] w);
    list_we = 1'b1;
    list_addr = 4'(idx);
    list_wdata = w;
    cyc_step();
  endtask

  task automatic start_frame();
    vga_y = '0;
    vga_blank = 1'b0;
    frame_start = 1'b1;
    cyc_step();
  endtask

  // Monitor: a copper write pops the scoreboard, anything else must be CPU pass-through.
  always @(negedge clk) begin
    if (mon_on) begin
      cpu_hold = !cpu_write_ready && (cpu_data_write_n != 2'b11);
      if (!cpu_write_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write addr=%h data=%h required=none (cycle %0d)", vga_address, vga_data_in, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("copper_write", {7'b0, vga_data_write_n, done, vga_address, vga_data_in, cyc[15:0]},
              {7'b0, 2'b00, e.l, e.a, 24'b0, e.d, e.c[15:0]});
        end
      end else begin
        chk("passthrough", {24'b0, done, vga_address, vga_data_in, vga_data_write_n},
            {24'b0, 1'b0, cpu_address, cpu_data_in, cpu_data_write_n});
        if (exp_q.size() != 0 && exp_q[0].c < cyc) begin
          checks++;
          errors++;
          $display("FAIL missed_write actual=none required_cycle=%0d addr=%h", exp_q[0].c, exp_q[0].a);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    frame_start = 1'b0;
    vga_y = '0;
    vga_blank = 1'b0;
    list_we = 1'b0;
    list_addr = '0;
    list_wdata = '0;
    cpu_address = 6'h05;
    cpu_data_in = 32'h1234_5678;
    cpu_data_write_n = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_write_n", 64'(vga_data_write_n), 64'(2'b11));
    chk("reset_ready", 64'(cpu_write_ready), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_pc", 64'(pc), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    mon_on = 1;

    // Single END entry at line 5.
    wr_entry(0, entry(5, 1, 6'h30, 8'h2A));
    enable = 1'b1;
    start_frame();
    for (int y = 0; y <= 6; y++) line(y, 4, 6);
    chk("single_done_busy", 64'(busy), 64'd0);
    chk("single_done_pc", 64'(pc), 64'd0);

    // Same-line burst with a held CPU write colliding.
    enable = 1'b0;
    wr_entry(0, entry(3, 0, 6'h30, 8'h01));
    wr_entry(1, entry(3, 0, 6'h31, 8'h02));
    wr_entry(2, entry(3, 1, 6'h32, 8'h03));
    enable = 1'b1;
    cpu_address = 6'h31;
    cpu_data_in = 32'h15;
    cpu_data_write_n = 2'b00;
    start_frame();
    for (int y = 0; y <= 4; y++) line(y, 4, 12);
    chk("burst_pc", 64'(pc), 64'd2);
    chk("burst_busy", 64'(busy), 64'd0);
    cpu_data_write_n = 2'b11;

    // Restart while waiting on entry 2.
    enable = 1'b0;
    wr_entry(0, entry(2, 0, 6'h10, 8'hA0));
    wr_entry(1, entry(4, 0, 6'h11, 8'hA1));
    wr_entry(2, entry(6, 1, 6'h12, 8'hA2));
    enable = 1'b1;
    start_frame();
    for (int y = 0; y <= 4; y++) line(y, 3, 8);
    vga_y = 10'd5;
    vga_blank = 1'b0;
    repeat (2) cyc_step();
    chk("restart_pc_before", 64'(pc), 64'd2);
    chk("restart_busy_before", 64'(busy), 64'd1);
    frame_start = 1'b1;
    vga_y = '0;
    cyc_step();
    chk("restart_pc_after", 64'(pc), 64'd0);
    for (int y = 0; y <= 6; y++) line(y, 3, 8);

    // Disable while waiting.
    enable = 1'b0;
    wr_entry(0, entry(5, 1, 6'h20, 8'h55));
    enable = 1'b1;
    start_frame();
    repeat (3) cyc_step();
    enable = 1'b0;
    cyc_step();
    chk("disable_busy", 64'(busy), 64'd0);
    chk("disable_pc", 64'(pc), 64'd0);
    for (int y = 0; y <= 7; y++) line(y, 3, 6);
    start_frame();
    for (int y = 0; y <= 7; y++) line(y, 3, 6);

    // Randomized frames.
    for (int i = 0; i < DEPTH; i++) wr_entry(i, rand_entry());
    rnd_on = 1;
    for (int f = 0; f < 30; f++) begin
      enable = ($urandom_range(0, 9) != 0);
      frame_start = 1'b1;
      vga_blank = 1'b1;
      cyc_step();
      for (int y = 0; y < 16; y++) line(y, $urandom_range(2, 10), $urandom_range(1, 30));
    end
    rnd_on = 0;
    enable = 1'b0;
    cpu_data_write_n = 2'b11;
    repeat (4) cyc_step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
